// File: rtl/uart_rx_param.sv
// Parameterisable UART receiver: 2-flop synchroniser, mid-bit sampling, optional parity,
// one or two stop bits, single-cycle result strobe with error qualifiers.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 2605,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 input_stream,
  output logic [DATA_BITS-1:0] output_stream,
  output logic                 rx_valid,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   MID       = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0]   LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic            LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic            ODD       = (PARITY == 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t                 state;
  logic [1:0]             sync;
  logic                   rxs;
  logic [CW-1:0]          cnt;
  logic [3:0]             bit_idx;
  logic                   stop_idx;
  logic [DATA_BITS-1:0]   shift;
  logic                   par_err;
  logic                   frm_err;
  logic                   armed;

  assign rxs = sync[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync          <= '1;
      state         <= ST_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      stop_idx      <= 1'b0;
      shift         <= '0;
      par_err       <= 1'b0;
      frm_err       <= 1'b0;
      armed         <= 1'b1;
      output_stream <= '0;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      frame_error   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      sync         <= {sync[0], input_stream};
      rx_valid     <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;

      case (state)
        ST_IDLE: begin
          // After a framing error the line must be seen high before re-arming (break handling).
          if (!armed) begin
            armed <= rxs;
          end else if (!rxs) begin
            state <= ST_START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        ST_START: begin
          if (cnt == MID) begin
            cnt <= '0;
            if (!rxs) begin
              state   <= ST_DATA;
              bit_idx <= '0;
              par_err <= 1'b0;
              frm_err <= 1'b0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_DATA: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            shift <= {rxs, shift[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              state    <= (PARITY != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_PARITY: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            par_err <= ((^shift) ^ rxs) != ODD;
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (stop_idx == LAST_STOP) begin
              state         <= ST_IDLE;
              busy          <= 1'b0;
              output_stream <= shift;
              rx_valid      <= 1'b1;
              parity_error  <= par_err;
              frame_error   <= frm_err | ~rxs;
              armed         <= ~(frm_err | ~rxs);
            end else begin
              stop_idx <= 1'b1;
              frm_err  <= frm_err | ~rxs;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations driven with directed frames, checked each
// cycle against a frame-level expectation queue plus literal spot checks.
module tb_uart_rx_param;

  localparam int CPB = 16;
  localparam int DBW [3] = '{8, 8, 7};
  localparam int PM  [3] = '{0, 1, 0};
  localparam int SB  [3] = '{1, 1, 2};

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    int         lo;
    int         hi;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       line [3];
  logic [7:0] os0, os1;
  logic [6:0] os2;
  logic [8:0] dout [3];
  logic       rv [3], pe [3], fe [3], bz [3];

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   model_on = 1'b0;
  exp_t q [3][$];
  logic [8:0] last [3];
  logic lperr [3], lferr [3], dpe [3], dfe [3];
  int   strobes [3], scyc [3], scyc_prev [3];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign dout[0] = {1'b0, os0};
  assign dout[1] = {1'b0, os1};
  assign dout[2] = {2'b00, os2};

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clock(clock), .reset(reset), .input_stream(line[0]), .output_stream(os0),
    .rx_valid(rv[0]), .parity_error(pe[0]), .frame_error(fe[0]), .busy(bz[0]));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u1 (
    .clock(clock), .reset(reset), .input_stream(line[1]), .output_stream(os1),
    .rx_valid(rv[1]), .parity_error(pe[1]), .frame_error(fe[1]), .busy(bz[1]));

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u2 (
    .clock(clock), .reset(reset), .input_stream(line[2]), .output_stream(os2),
    .rx_valid(rv[2]), .parity_error(pe[2]), .frame_error(fe[2]), .busy(bz[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (model_on && !reset) begin
      for (int i = 0; i < 3; i++) begin
        if (rv[i] === 1'b1) begin
          strobes[i]++;
          scyc_prev[i] = scyc[i];
          scyc[i] = cyc;
          dpe[i] = pe[i];
          dfe[i] = fe[i];
          if (q[i].size() == 0) begin
            chk($sformatf("unexpected_strobe%0d", i), rv[i], 1'b0);
          end else begin
            e = q[i].pop_front();
            chk($sformatf("data%0d", i), dout[i], e.data);
            chk($sformatf("parity_err%0d", i), pe[i], e.perr);
            chk($sformatf("frame_err%0d", i), fe[i], e.ferr);
            chk($sformatf("strobe_not_early%0d", i), cyc >= e.lo, 1);
            chk($sformatf("strobe_not_late%0d", i), cyc <= e.hi, 1);
            last[i]  = e.data;
            lperr[i] = e.perr;
            lferr[i] = e.ferr;
          end
        end else begin
          chk($sformatf("hold%0d", i), dout[i], last[i]);
          chk($sformatf("perr_idle%0d", i), pe[i], 1'b0);
          chk($sformatf("ferr_idle%0d", i), fe[i], 1'b0);
          if (q[i].size() != 0 && cyc > q[i][0].hi) begin
            chk($sformatf("strobe_by_deadline%0d", i), rv[i], 1'b1);
            void'(q[i].pop_front());
          end
        end
      end
    end
  end

  task automatic pulse_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      last[i] = '0;
    end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Caller must be positioned 1 time unit after a rising edge; frames follow each other with no gap.
  task automatic send(input int i, input logic [8:0] data, input logic pbit, input logic stopv,
                      input int abort_at);
    logic [15:0] bits;
    logic [8:0]  mask;
    exp_t        e;
    int          nb;
    int          p;
    mask = 9'((1 << DBW[i]) - 1);
    nb   = 1 + DBW[i] + ((PM[i] != 0) ? 1 : 0) + SB[i];
    bits = '1;
    bits[0] = 1'b0;
    for (int j = 0; j < DBW[i]; j++) bits[1+j] = data[j];
    p = 1 + DBW[i];
    if (PM[i] != 0) begin
      bits[p] = pbit;
      p++;
    end
    for (int s = 0; s < SB[i]; s++) bits[p+s] = stopv;
    e.data = data & mask;
    e.perr = (PM[i] != 0) && ((((^(data & mask)) ^ pbit) != (PM[i] == 2)));
    e.ferr = !stopv;
    e.lo   = cyc + CPB * (nb - 1) + CPB / 2;
    e.hi   = e.lo + 4;
    if (abort_at < 0) q[i].push_back(e);
    for (int b = 0; b < nb; b++) begin
      line[i] = bits[b];
      if (b == abort_at) begin
        repeat (CPB / 2) @(posedge clock);
        #1;
        pulse_reset();
        line[i] = 1'b1;
        return;
      end
      repeat (CPB) @(posedge clock);
      #1;
    end
  endtask

  task automatic drain(input int i);
    for (int k = 0; k < 4 * CPB && q[i].size() != 0; k++) begin
      @(posedge clock); #1;
    end
    chk($sformatf("drain%0d", i), q[i].size(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    int cnt;
    int t;
    for (int i = 0; i < 3; i++) begin
      line[i] = 1'b1;
      last[i] = '0;
    end
    reset = 1'b1;
    idle(4);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_data%0d", i), dout[i], 9'h000);
      chk($sformatf("reset_valid%0d", i), rv[i], 1'b0);
      chk($sformatf("reset_busy%0d", i), bz[i], 1'b0);
      chk($sformatf("reset_flags%0d", i), {pe[i], fe[i]}, 2'b00);
    end
    model_on = 1'b1;
    idle(20);

    // Basic frame, no parity, one stop bit.
    send(0, 9'h093, 1'b0, 1'b1, -1);
    drain(0);
    idle(4);
    chk("basic_strobes", strobes[0], 1);
    chk("basic_model_data", last[0], 9'h093);
    chk("basic_dut_data", os0, 8'h93);
    chk("basic_flags", {dpe[0], dfe[0]}, 2'b00);
    chk("basic_busy_after", bz[0], 1'b0);

    // Even parity: 0x93 has four ones, so parity bit 1 is wrong and 0 is right.
    send(1, 9'h093, 1'b1, 1'b1, -1);
    drain(1);
    chk("par_wrong_model", lperr[1], 1'b1);
    chk("par_wrong_flag", dpe[1], 1'b1);
    chk("par_wrong_data", os1, 8'h93);
    idle(CPB);
    send(1, 9'h093, 1'b0, 1'b1, -1);
    drain(1);
    chk("par_right_model", lperr[1], 1'b0);
    chk("par_right_flag", dpe[1], 1'b0);
    chk("par_strobes", strobes[1], 2);

    // Framing error followed by a held-low line, then recovery.
    n = strobes[0];
    send(0, 9'h0A5, 1'b0, 1'b0, -1);
    drain(0);
    chk("ferr_model", lferr[0], 1'b1);
    chk("ferr_flag", dfe[0], 1'b1);
    chk("ferr_data", os0, 8'hA5);
    idle(3 * CPB);
    chk("break_one_strobe", strobes[0] - n, 1);
    chk("break_not_busy", bz[0], 1'b0);
    line[0] = 1'b1;
    idle(2 * CPB);
    send(0, 9'h03C, 1'b0, 1'b1, -1);
    drain(0);
    chk("recover_data", os0, 8'h3C);
    chk("recover_flag", dfe[0], 1'b0);
    chk("recover_strobes", strobes[0] - n, 2);

    // Short low glitch on an idle line.
    n = strobes[0];
    idle(CPB);
    line[0] = 1'b0;
    idle(4);
    line[0] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 3 * CPB; k++) begin
      @(posedge clock); #1;
      if (bz[0] === 1'b1) cnt++;
    end
    chk("glitch_busy_pulse", (cnt > 0) && (cnt < CPB), 1);
    chk("glitch_busy_end", bz[0], 1'b0);
    chk("glitch_no_strobe", strobes[0] - n, 0);

    // Reset during data bit 3 of 0x5A, then a clean frame.
    n = strobes[0];
    send(0, 9'h05A, 1'b0, 1'b1, 4);
    chk("abort_data0", os0, 8'h00);
    chk("abort_data1", os1, 8'h00);
    chk("abort_valid", rv[0], 1'b0);
    chk("abort_busy", bz[0], 1'b0);
    chk("abort_flags", {pe[0], fe[0]}, 2'b00);
    idle(2 * CPB);
    chk("abort_no_strobe", strobes[0] - n, 0);
    send(0, 9'h0C3, 1'b0, 1'b1, -1);
    drain(0);
    chk("after_abort_data", os0, 8'hC3);
    chk("after_abort_strobes", strobes[0] - n, 1);

    // Seven data bits, two stop bits, back-to-back frames.
    t = cyc;
    send(2, 9'h055, 1'b0, 1'b1, -1);
    send(2, 9'h02A, 1'b0, 1'b1, -1);
    drain(2);
    chk("b2b_strobes", strobes[2], 2);
    chk("b2b_spacing", (scyc[2] - scyc_prev[2] >= (1+7+2)*CPB - 1) &&
                       (scyc[2] - scyc_prev[2] <= (1+7+2)*CPB + 1), 1);
    chk("b2b_within_two_frames", (scyc[2] - t) <= 2 * (1+7+2) * CPB, 1);
    chk("b2b_last_data", os2, 7'h2A);
    chk("b2b_flags", {dpe[2], dfe[2]}, 2'b00);
    idle(CPB);

    for (int i = 0; i < 3; i++) chk($sformatf("leftover%0d", i), q[i].size(), 0);
    model_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
